vga_pixel_shifter: RTL
======================

Name: vga_pixel_shifter

Overview:
- Downstream of the video word store and upstream of the colour/sync output mux in the TinyQV VGA peripheral.
- Fetches 32-bit bitmap words over a req/ack handshake and double-buffers them: one word shifting, one prefetched.
- Emits one registered 1-bit pixel per clock while active video is high, with programmable horizontal pixel repetition.
- Flags underruns when the word supply cannot keep up.

Parameters:
- WORD_W, 32, bits per bitmap word; power of two, at least 8.
- SCALE_W, 3, width of the repeat-count field; each pixel lasts scale+1 clocks.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- line_flush  in  1  one-cycle pulse at the start of horizontal blanking; discards buffered data
- active  in  1  high on every clock of visible video
- scale  in  SCALE_W  pixel repeat count minus one; sampled only on line_flush
- word_req  out  1  high when the prefetch buffer is empty
- word_ack  in  1  word_data is valid this cycle; honoured only while word_req is high
- word_data  in  WORD_W  bitmap word; bit 0 is the leftmost pixel
- pixel  out  1  registered pixel, 1 = foreground
- underrun  out  1  sticky flag: active video occurred with no word loaded
- clear_underrun  in  1  clears underrun

Behaviour:
- State:
  - shift_reg[WORD_W], shift_valid
  - next_reg[WORD_W], next_valid
  - bit_cnt[log2 WORD_W]
  - rep_cnt[SCALE_W]
  - scale_q[SCALE_W]
- Reset (rst_n=0 at posedge): shift_valid=0, next_valid=0, bit_cnt=0, rep_cnt=0, scale_q=0, pixel=0, underrun=0. Reset mid-line discards all data. word_req=1 in the first cycle after reset.
- word_req = !next_valid (combinational).
- Accept: word_ack && word_req at posedge -> next_reg<=word_data, next_valid<=1. word_ack without word_req is ignored.
- Consume condition (C): active && shift_valid.
  - Under C, if rep_cnt==scale_q: rep_cnt<=0, bit_cnt<=bit_cnt+1.
  - Under C, otherwise: rep_cnt<=rep_cnt+1.
- Last pixel (L): C && bit_cnt==WORD_W-1 && rep_cnt==scale_q.
- Transfer: if (!shift_valid || L) && next_valid:
  - shift_reg<=next_reg, shift_valid<=1, next_valid<=0, bit_cnt<=0, rep_cnt<=0.
  - Accept and transfer are mutually exclusive in a cycle, because accept needs next_valid=0 and transfer needs next_valid=1.
  - If L && !next_valid: shift_valid<=0.
- Pixel (1-cycle latency from active):
  - pixel <= (active && shift_valid) ? shift_reg[bit_cnt] : 0.
  - The value uses pre-update state.
- Underrun: active && !shift_valid -> underrun<=1 and that pixel is 0. On the same cycle, set wins over clear_underrun. Otherwise clear_underrun -> 0.
- line_flush:
  - Highest priority: shift_valid<=0, next_valid<=0, bit_cnt<=0, rep_cnt<=0, scale_q<=scale.
  - A word_ack in the same cycle is discarded; word_req stays high the next cycle.
  - The underrun flag is unaffected.
  - pixel<=0 on that cycle.
- Fill after flush: with word_ack returned immediately, the first word reaches shift_reg 2 cycles after the ack and the second word fills next_reg. Both buffers are full before active when blanking is at least 4 cycles.
- Steady state: one word is needed every WORD_W*(scale_q+1) active clocks. A word arriving any time before L avoids underrun.
- Active dropping mid-word freezes bit_cnt/rep_cnt; shifting resumes where it stopped when active returns.

Test Plan:
- scale=0, flush, ack 0x0000_00A5 then 0xFFFF_0000 immediately, then 64 clocks of active -> pixel stream 1,0,1,0,0,1,0,1, then 24 zeros, then 16 zeros and 16 ones, each pixel 1 cycle after active; underrun=0.
- scale=1, word 0x0000_0003 -> pixels 1,1,1,1 then 0s for 60 clocks; word_req rises exactly when the word moves into shift_reg.
- Supply a single word, then hold word_ack low; active for 40 clocks at scale=0 -> 32 data pixels, then 0s; underrun=1 from the clock after the 33rd active cycle; pulse clear_underrun with active low -> 0.
- Flush after 10 active pixels with word_ack asserted the same cycle -> buffers empty, ack data dropped, word_req=1 the next cycle; the new line starts from bit 0 of the next acked word.
- word_ack pulsed while both buffers are full -> no state change. Change scale mid-line from 0 to 3 -> no effect until the next line_flush.
- Assert rst_n=0 for 1 cycle mid-word -> pixel=0, underrun=0, word_req=1; output resumes correctly after a flush and refill.

Source files
------------

// File: rtl/vga_pixel_shifter_if.sv
// Word-fetch handshake between the pixel shifter and the video word store.
//   word_req  : shifter -> store, prefetch buffer is empty
//   word_ack  : store -> shifter, word_data valid this cycle
//   word_data : store -> shifter, bitmap word, bit 0 = leftmost pixel
// master is the shifter side (issues requests), slave is the word store.
interface vga_pixel_shifter_if #(
  parameter int WORD_W = 32
) ();
  logic              word_req;
  logic              word_ack;
  logic [WORD_W-1:0] word_data;

  modport master (output word_req, input word_ack, input word_data);
  modport slave  (input word_req, output word_ack, output word_data);
endinterface

// File: rtl/vga_pixel_shifter.sv
// VGA pixel shifter: double-buffers bitmap words fetched over a req/ack
// handshake and serialises them into one registered pixel per clock of
// active video, with each pixel repeated scale+1 clocks.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   line_flush_i       start-of-blanking pulse, discards buffered words
//   active_i           visible video this clock
//   scale_i            repeat count minus one, captured on line_flush_i
//   wbus               word fetch handshake (master side)
//   pixel_o            registered pixel, 1 = foreground
//   underrun_o         sticky: active video seen with no word loaded
//   clear_underrun_i   clears underrun_o (a same-cycle set wins)
module vga_pixel_shifter #(
  parameter int WORD_W  = 32,
  parameter int SCALE_W = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       line_flush_i,
  input  logic                       active_i,
  input  logic [SCALE_W-1:0]         scale_i,
  vga_pixel_shifter_if.master        wbus,
  output logic                       pixel_o,
  output logic                       underrun_o,
  input  logic                       clear_underrun_i
);

  localparam int BCW = $clog2(WORD_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

  logic [WORD_W-1:0]  shift_reg_q, shift_reg_d;
  logic               shift_valid_q, shift_valid_d;
  logic [WORD_W-1:0]  next_reg_q, next_reg_d;
  logic               next_valid_q, next_valid_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SCALE_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic               pixel_q, pixel_d;
  logic               underrun_q, underrun_d;

  logic consume, rep_done, last_pix, accept, transfer;

  assign wbus.word_req = !next_valid_q;

  assign consume  = active_i && shift_valid_q;
  assign rep_done = (rep_cnt_q == scale_q);
  assign last_pix = consume && (bit_cnt_q == LAST_BIT) && rep_done;
  // accept needs next empty, transfer needs next full: never both at once
  assign accept   = wbus.word_ack && !next_valid_q;
  assign transfer = (!shift_valid_q || last_pix) && next_valid_q;

  always_comb begin
    shift_reg_d   = shift_reg_q;
    shift_valid_d = shift_valid_q;
    next_reg_d    = next_reg_q;
    next_valid_d  = next_valid_q;
    bit_cnt_d     = bit_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    scale_d       = scale_q;
    pixel_d       = consume ? shift_reg_q[bit_cnt_q] : 1'b0;
    underrun_d    = underrun_q;

    if (consume) begin
      if (rep_done) begin
        rep_cnt_d = '0;
        bit_cnt_d = bit_cnt_q + BCW'(1);
      end else begin
        rep_cnt_d = rep_cnt_q + SCALE_W'(1);
      end
    end

    if (accept) begin
      next_reg_d   = wbus.word_data;
      next_valid_d = 1'b1;
    end

    if (transfer) begin
      shift_reg_d   = next_reg_q;
      shift_valid_d = 1'b1;
      next_valid_d  = 1'b0;
      bit_cnt_d     = '0;
      rep_cnt_d     = '0;
    end else if (last_pix) begin
      shift_valid_d = 1'b0;
    end

    // set beats clear; the flush below leaves the flag alone
    if (active_i && !shift_valid_q)
      underrun_d = 1'b1;
    else if (clear_underrun_i)
      underrun_d = 1'b0;

    // flush overrides everything, including a same-cycle accept
    if (line_flush_i) begin
      shift_valid_d = 1'b0;
      next_valid_d  = 1'b0;
      bit_cnt_d     = '0;
      rep_cnt_d     = '0;
      scale_d       = scale_i;
      pixel_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg_q   <= '0;
      shift_valid_q <= 1'b0;
      next_reg_q    <= '0;
      next_valid_q  <= 1'b0;
      bit_cnt_q     <= '0;
      rep_cnt_q     <= '0;
      scale_q       <= '0;
      pixel_q       <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      shift_reg_q   <= shift_reg_d;
      shift_valid_q <= shift_valid_d;
      next_reg_q    <= next_reg_d;
      next_valid_q  <= next_valid_d;
      bit_cnt_q     <= bit_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      scale_q       <= scale_d;
      pixel_q       <= pixel_d;
      underrun_q    <= underrun_d;
    end
  end

  assign pixel_o    = pixel_q;
  assign underrun_o = underrun_q;

endmodule
